// File: rtl/gat_pkg.sv
// rtl/gat_pkg.sv - shared GAT layer-1 constants, types and coefficient-collector state enum
package gat_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int COEF_WIDTH     = 2*DATA_WIDTH+6;
    localparam int ALPHA_SHIFT    = 2;
    localparam int NUM_OF_NODES   = 168;
    localparam int NUM_NODE_WIDTH = $clog2(NUM_OF_NODES)+1;

    typedef logic signed [COEF_WIDTH-1:0] coef_t;
    typedef logic [NUM_NODE_WIDTH-1:0]    node_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } coef_state_e;

endpackage

// File: rtl/leaky_relu.sv
// rtl/leaky_relu.sv - combinational LeakyReLU with power-of-two negative slope
module leaky_relu #(
    parameter int WIDTH = gat_pkg::COEF_WIDTH,
    parameter int SHIFT = gat_pkg::ALPHA_SHIFT
) (
    input  logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y
);

    // Arithmetic shift rounds negatives toward -inf.
    assign y = x[WIDTH-1] ? (x >>> SHIFT) : x;

endmodule

// File: rtl/coef_leaky_collector.sv
// rtl/coef_leaky_collector.sv - buffers one subgraph of LeakyReLU'd DMVM products and streams them out (COEF_MAX_SUB_EN: max-normalised)
module coef_leaky_collector #(
    parameter int DATA_WIDTH     = gat_pkg::DATA_WIDTH,
    parameter int COEF_WIDTH     = 2*DATA_WIDTH+6,
    parameter int NUM_OF_NODES   = gat_pkg::NUM_OF_NODES,
    parameter int ALPHA_SHIFT    = gat_pkg::ALPHA_SHIFT,
    parameter int NUM_NODE_WIDTH = $clog2(NUM_OF_NODES)+1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             dmvm_valid_i,
    output logic                             dmvm_ready_o,
    input  logic signed [COEF_WIDTH-1:0]     dmvm_coef_i,
    input  logic        [NUM_NODE_WIDTH-1:0] dmvm_num_nodes_i,
    output logic                             coef_valid_o,
    input  logic                             coef_ready_i,
    output logic signed [COEF_WIDTH-1:0]     coef_o,
    output logic                             coef_last_o,
    output logic        [NUM_NODE_WIDTH-1:0] coef_num_nodes_o,
    output logic                             overflow_o
);
    import gat_pkg::*;

    localparam int ADDR_WIDTH = $clog2(NUM_OF_NODES);

    typedef logic signed [COEF_WIDTH-1:0] lcoef_t;
    typedef logic [NUM_NODE_WIDTH-1:0]    cnt_t;

    localparam lcoef_t COEF_MIN = {1'b1, {(COEF_WIDTH-1){1'b0}}};
    localparam cnt_t   CNT_ONE  = cnt_t'(1);
    localparam cnt_t   CNT_MAX  = cnt_t'(NUM_OF_NODES);

    coef_state_e state;
    cnt_t        n_reg, wr_cnt, rd_cnt, n_in, n_last, rd_idx;
    logic        ready_reg, valid_reg, ovf_reg;
    logic        in_fire, rd_load;
    lcoef_t      y, rd_data, out_val;
    lcoef_t      mem [NUM_OF_NODES];
    logic [ADDR_WIDTH-1:0] wr_addr;

    leaky_relu #(.WIDTH(COEF_WIDTH), .SHIFT(ALPHA_SHIFT)) u_leaky_relu (
        .x (dmvm_coef_i),
        .y (y)
    );

    always_comb begin
        n_in = dmvm_num_nodes_i;
        if (dmvm_num_nodes_i == '0)
            n_in = CNT_ONE;
        else if (dmvm_num_nodes_i > CNT_MAX)
            n_in = CNT_MAX;
    end

    assign in_fire = dmvm_valid_i && ready_reg;
    assign n_last  = n_reg - CNT_ONE;
    assign wr_addr = (state == IDLE) ? '0 : wr_cnt[ADDR_WIDTH-1:0];
    // Prefetch the next entry on each accepted output so the stream runs 1/cycle.
    assign rd_idx  = valid_reg ? (rd_cnt + CNT_ONE) : rd_cnt;
    assign rd_load = (state == DRAIN) &&
                     (!valid_reg || (coef_ready_i && (rd_cnt != n_last)));

    always_ff @(posedge clk) begin
        if (in_fire)
            mem[wr_addr] <= y;
        if (rd_load)
            rd_data <= mem[rd_idx[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n_reg     <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_fire) begin
                    n_reg  <= n_in;
                    wr_cnt <= CNT_ONE;
                    rd_cnt <= '0;
                    if (dmvm_num_nodes_i > CNT_MAX)
                        ovf_reg <= 1'b1;
                    if (n_in == CNT_ONE) begin
                        state     <= DRAIN;
                        ready_reg <= 1'b0;
                    end else begin
                        state <= COLLECT;
                    end
                end
                COLLECT: if (in_fire) begin
                    if (wr_cnt == n_last) begin
                        state     <= DRAIN;
                        ready_reg <= 1'b0;
                    end else begin
                        wr_cnt <= wr_cnt + CNT_ONE;
                    end
                end
                DRAIN: begin
                    if (!valid_reg) begin
                        valid_reg <= 1'b1;
                    end else if (coef_ready_i) begin
                        if (rd_cnt == n_last) begin
                            valid_reg <= 1'b0;
                            rd_cnt    <= '0;
                            ready_reg <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            rd_cnt <= rd_cnt + CNT_ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COEF_MAX_SUB_EN
    lcoef_t                    max_reg;
    logic signed [COEF_WIDTH:0] diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            max_reg <= COEF_MIN;
        else if (in_fire && ((state == IDLE) || (y > max_reg)))
            max_reg <= y;
    end

    always_comb begin
        diff = {rd_data[COEF_WIDTH-1], rd_data} - {max_reg[COEF_WIDTH-1], max_reg};
        if (diff[COEF_WIDTH] != diff[COEF_WIDTH-1])
            out_val = diff[COEF_WIDTH] ? COEF_MIN : ~COEF_MIN;
        else
            out_val = diff[COEF_WIDTH-1:0];
    end
`else
    assign out_val = rd_data;
`endif

    assign dmvm_ready_o     = ready_reg;
    assign coef_valid_o     = valid_reg;
    assign coef_o           = valid_reg ? out_val : '0;
    assign coef_last_o      = valid_reg && (rd_cnt == n_last);
    assign coef_num_nodes_o = n_reg;
    assign overflow_o       = ovf_reg;

endmodule

// File: tb/tb_coef_leaky_collector.sv
// tb/tb_coef_leaky_collector.sv - table-driven scoreboard bench for coef_leaky_collector
`timescale 1ns/1ps
module tb_coef_leaky_collector;

    localparam int W    = 22;
    localparam int NW   = 9;
    localparam int MAXN = 168;
    localparam int CMIN = -(1 << (W-1));

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 dmvm_valid_i = 1'b0;
    logic                 dmvm_ready_o;
    logic signed [W-1:0]  dmvm_coef_i = '0;
    logic [NW-1:0]        dmvm_num_nodes_i = '0;
    logic                 coef_valid_o;
    logic                 coef_ready_i = 1'b0;
    logic signed [W-1:0]  coef_o;
    logic                 coef_last_o;
    logic [NW-1:0]        coef_num_nodes_o;
    logic                 overflow_o;

    always #5 clk = ~clk;

    coef_leaky_collector dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dmvm_valid_i     (dmvm_valid_i),
        .dmvm_ready_o     (dmvm_ready_o),
        .dmvm_coef_i      (dmvm_coef_i),
        .dmvm_num_nodes_i (dmvm_num_nodes_i),
        .coef_valid_o     (coef_valid_o),
        .coef_ready_i     (coef_ready_i),
        .coef_o           (coef_o),
        .coef_last_o      (coef_last_o),
        .coef_num_nodes_o (coef_num_nodes_o),
        .overflow_o       (overflow_o)
    );

    typedef struct {
        int         n_cfg;
        int         cnt;
        int         din[4];
        int         dexp[4];
        logic [7:0] rdy;
    } vec_t;

    vec_t tbl[6];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   sb_data[$];
    bit   sb_last[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lrelu(input int x);
        if (x >= 0) return x;
        return -((-x + 3) / 4);
    endfunction

    function automatic int norm(input int yv, input int m);
`ifdef COEF_MAX_SUB_EN
        int d;
        d = yv - m;
        if (d < CMIN) d = CMIN;
        return d;
`else
        return yv + 0 * m;
`endif
    endfunction

    task automatic drain(input logic [7:0] pat, input int eff, input int budget);
        bit                  first = 1'b1;
        bit                  pv = 1'b0;
        bit                  pr = 1'b1;
        bit                  pl = 1'b0;
        logic signed [W-1:0] pc = '0;
        int                  k = 0;
        while (sb_data.size() > 0 && k < budget) begin
            @(negedge clk);
            coef_ready_i = (k < 8) ? pat[k] : 1'b1;
            if (pv && !pr) begin
                chk("stall_data", coef_o, pc);
                chk("stall_last", coef_last_o, pl);
            end
            if (coef_valid_o) begin
                if (first) begin
                    chk("latency", k, 0);
                    chk("num_nodes", coef_num_nodes_o, eff);
                    first = 1'b0;
                end
                chk("drain_in_ready", dmvm_ready_o, 0);
                if (coef_ready_i) begin
                    chk("coef", coef_o, sb_data.pop_front());
                    chk("last", coef_last_o, sb_last.pop_front());
                end
            end
            pv = coef_valid_o;
            pr = coef_ready_i;
            pc = coef_o;
            pl = coef_last_o;
            k++;
        end
        if (sb_data.size() > 0) begin
            chk("drain_timeout", sb_data.size(), 0);
            sb_data.delete();
            sb_last.delete();
        end
        @(negedge clk);
        coef_ready_i = 1'b0;
        chk("idle_ready", dmvm_ready_o, 1);
        chk("idle_valid", coef_valid_o, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int eff;
        eff = (v.n_cfg == 0) ? 1 : v.n_cfg;
        for (int i = 0; i < v.cnt; i++) begin
            @(negedge clk);
            chk("in_ready", dmvm_ready_o, 1);
            dmvm_valid_i     = 1'b1;
            dmvm_coef_i      = W'(v.din[i]);
            dmvm_num_nodes_i = NW'(v.n_cfg);
            sb_data.push_back(v.dexp[i]);
            sb_last.push_back(i == v.cnt - 1);
        end
        @(negedge clk);
        dmvm_valid_i = 1'b0;
        chk("enter_drain_ready", dmvm_ready_o, 0);
        chk("enter_drain_valid", coef_valid_o, 0);
        drain(v.rdy, eff, 64);
    endtask

    initial begin
        int xs[MAXN];
        int acc;
        int m;

        tbl[0] = '{n_cfg: 4, cnt: 4, din: '{10, -8, 3, 20}, dexp: '{0, 0, 0, 0}, rdy: 8'hFF};
        tbl[1] = '{n_cfg: 1, cnt: 1, din: '{-4, 0, 0, 0},   dexp: '{0, 0, 0, 0}, rdy: 8'hFF};
        tbl[2] = '{n_cfg: 3, cnt: 3, din: '{5, 6, 7, 0},    dexp: '{0, 0, 0, 0}, rdy: 8'hE9};
        tbl[3] = '{n_cfg: 2, cnt: 2, din: '{CMIN, -CMIN-1, 0, 0}, dexp: '{0, 0, 0, 0}, rdy: 8'hFF};
        tbl[4] = '{n_cfg: 0, cnt: 1, din: '{7, 0, 0, 0},    dexp: '{0, 0, 0, 0}, rdy: 8'hFF};
        tbl[5] = '{n_cfg: 2, cnt: 2, din: '{10, -8, 0, 0},  dexp: '{0, 0, 0, 0}, rdy: 8'hFF};
`ifdef COEF_MAX_SUB_EN
        tbl[0].dexp = '{-10, -22, -17, 0};
        tbl[1].dexp = '{0, 0, 0, 0};
        tbl[2].dexp = '{-2, -1, 0, 0};
        tbl[3].dexp = '{CMIN, 0, 0, 0};
        tbl[4].dexp = '{0, 0, 0, 0};
        tbl[5].dexp = '{0, -12, 0, 0};
`else
        tbl[0].dexp = '{10, -2, 3, 20};
        tbl[1].dexp = '{-1, 0, 0, 0};
        tbl[2].dexp = '{5, 6, 7, 0};
        tbl[3].dexp = '{-524288, 2097151, 0, 0};
        tbl[4].dexp = '{7, 0, 0, 0};
        tbl[5].dexp = '{10, -2, 0, 0};
`endif

        repeat (3) @(negedge clk);
        chk("rst_in_ready", dmvm_ready_o, 1);
        chk("rst_valid", coef_valid_o, 0);
        chk("rst_coef", coef_o, 0);
        chk("rst_last", coef_last_o, 0);
        chk("rst_num_nodes", coef_num_nodes_o, 0);
        chk("rst_overflow", overflow_o, 0);
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++)
            run_vec(tbl[t]);
        chk("no_overflow_yet", overflow_o, 0);

        // Oversized subgraph: only NUM_OF_NODES inputs may be taken.
        acc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!dmvm_ready_o) break;
            xs[acc]          = ((i * 7919) % 20000) - 10000;
            dmvm_valid_i     = 1'b1;
            dmvm_coef_i      = W'(xs[acc]);
            dmvm_num_nodes_i = NW'(200);
            acc++;
        end
        dmvm_valid_i = 1'b0;
        chk("ovf_accepted", acc, MAXN);
        chk("ovf_flag", overflow_o, 1);
        m = lrelu(xs[0]);
        for (int i = 1; i < acc && i < MAXN; i++)
            if (lrelu(xs[i]) > m) m = lrelu(xs[i]);
        for (int i = 0; i < acc && i < MAXN; i++) begin
            sb_data.push_back(norm(lrelu(xs[i]), m));
            sb_last.push_back(i == acc - 1);
        end
        drain(8'hFF, MAXN, 400);
        chk("ovf_sticky", overflow_o, 1);

        // Reset in the middle of DRAIN.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dmvm_valid_i     = 1'b1;
            dmvm_coef_i      = W'(i + 1);
            dmvm_num_nodes_i = NW'(5);
        end
        @(negedge clk);
        dmvm_valid_i = 1'b0;
        coef_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_rst_valid", coef_valid_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", coef_valid_o, 0);
        chk("rst_mid_overflow", overflow_o, 0);
        chk("rst_mid_ready", dmvm_ready_o, 1);
        coef_ready_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run_vec(tbl[5]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
